// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and pipeline types.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_VIS        = 640;
  localparam int unsigned H_FP         = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BP         = 48;
  localparam int unsigned H_TOT        = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_VIS + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  // Vertical timing, in lines
  localparam int unsigned V_VIS        = 480;
  localparam int unsigned V_FP         = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BP         = 33;
  localparam int unsigned V_TOT        = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_VIS + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Datapath widths
  localparam int unsigned RGB_W = 8;
  localparam int unsigned CNT_W = 10;

  // Signals that travel together down the sync delay line
  typedef struct packed {
    logic hs;   // active-low hsync
    logic vs;   // active-low vsync
    logic vis;  // visible-area flag
  } sync_bits_t;

  // Inactive pipeline contents: syncs deasserted, blanking
  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  // Inclusive range test used for the sync windows
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth vector shift register with synchronous reset to a per-bit value.
module sync_delay_line #(
  parameter int unsigned       WIDTH   = 3,
  parameter int unsigned       DEPTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH*WIDTH-1:0] shreg;

  if (DEPTH == 1) begin : g_single
    // Single stage: plain register with reset value
    always_ff @(posedge clk) begin
      if (rst) begin
        shreg <= RST_VAL;
      end else begin
        shreg <= din;
      end
    end
  end else begin : g_multi
    // Shift din in at the low end; oldest entry sits at the top
    always_ff @(posedge clk) begin
      if (rst) begin
        shreg <= {DEPTH{RST_VAL}};
      end else begin
        shreg <= {shreg[(DEPTH-1)*WIDTH-1:0], din};
      end
    end
  end

  assign dout = shreg[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: coordinates, frame marker, delayed syncs and gated colour.
module vga_timing_gen #(
  parameter int unsigned H_VIS    = vga_pkg::H_VIS,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_VIS    = vga_pkg::V_VIS,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned RGB_W    = vga_pkg::RGB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [9:0]       pixel,
  output logic [8:0]       line,
  output logic             video_on,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb_out
);

  import vga_pkg::*;

  // Counter-width constants derived from the timing parameters
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  // Elaboration-time sanity checks on the configuration
  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be in 1..4");
  end
  if (H_VIS + H_FP + H_SYNC + H_BP > (1 << CNT_W)) begin : g_bad_h_tot
    $error("vga_timing_gen: horizontal total exceeds counter range");
  end
  if (V_VIS + V_FP + V_SYNC + V_BP > (1 << CNT_W)) begin : g_bad_v_tot
    $error("vga_timing_gen: vertical total exceeds counter range");
  end
  if (H_VIS > 1023 || V_VIS > 511) begin : g_bad_vis
    $error("vga_timing_gen: visible area exceeds pixel/line width");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic       vis_raw;
  logic       hs_raw;
  logic       vs_raw;
  sync_bits_t stage1;
  sync_bits_t dly_out;
  logic [RGB_W-1:0] rgb_q;

  // Raster counters: h wraps every line, v advances on the h wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + CNT_W'(1);
      end
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Visibility and raw active-low sync windows decoded from the counters
  always_comb begin
    vis_raw = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    hs_raw  = !in_range(h_cnt, HS_START, HS_END);
    vs_raw  = !in_range(v_cnt, VS_START, VS_END);
  end

  // Stage 1: registered coordinates, frame marker and sync/vis bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel       <= '0;
      line        <= '0;
      frame_start <= 1'b0;
      stage1      <= SYNC_IDLE;
    end else begin
      pixel       <= vis_raw ? (h_cnt + CNT_W'(1)) : '0;
      line        <= vis_raw ? (v_cnt[8:0] + 9'd1) : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      stage1      <= '{hs: hs_raw, vs: vs_raw, vis: vis_raw};
    end
  end

  assign video_on = stage1.vis;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (stage1),
    .dout (dly_out)
  );

  assign hsync = dly_out.hs;
  assign vsync = dly_out.vs;

  // Colour capture register; cleared on reset so nothing stale leaks out
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_in;
    end
  end

  // Registering rgb_in and gating with the final vis tap is cycle-identical to
  // registering (vis tap PIPE_DLY-1 ? rgb_in : 0), and uses every delay-line bit.
  always_comb begin
    rgb_out = dly_out.vis ? rgb_q : '0;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shortened vertical raster.
module tb_vga_timing_gen;

  localparam int unsigned LINE  = 800;
  localparam int unsigned NLINE = 11;           // 4 visible + 2 fp + 2 sync + 3 bp
  localparam int unsigned FRAME = LINE * NLINE; // 8800 clocks

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rgb_in;
  logic [9:0] pixel;
  logic [8:0] line;
  logic       video_on;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb_out;

  int total = 0;
  int bad   = 0;
  int c;
  logic       mode;
  logic [7:0] layer_q;

  // model / accumulator variables
  int h, v, hd, vd, n, k;
  logic vis, visd, e_hs, e_vs, found, early_low, hs_at_658;
  int e_pix, e_line, e_rgb;
  int m_pix, m_line, m_von, m_fs, m_hs, m_vs, m_rgb, first_bad;
  int vis_cnt, pix0_line0, hs_low0, hs_first, vs_low, vs_first;
  int fs_cnt, fs_second, rgb_ff_cnt, rgb_nz_f1, rgb_in_hs, line_nz;

  always #20 clk = ~clk;

  // Stand-in for a layer block: colour for the first 15 pixels, registered
  always @(posedge clk) layer_q <= (pixel != 10'd0 && pixel <= 10'd15) ? 8'hA5 : 8'h00;

  assign rgb_in = mode ? layer_q : 8'hFF;

  vga_timing_gen #(
    .V_VIS    (4),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3),
    .PIPE_DLY (2),
    .RGB_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rgb_in      (rgb_in),
    .pixel       (pixel),
    .line        (line),
    .video_on    (video_on),
    .frame_start (frame_start),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_out     (rgb_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    c++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pixel"},  32'(pixel),       0);
    chk({tag, "_line"},   32'(line),        0);
    chk({tag, "_von"},    32'(video_on),    0);
    chk({tag, "_fs"},     32'(frame_start), 0);
    chk({tag, "_hsync"},  32'(hsync),       1);
    chk({tag, "_vsync"},  32'(vsync),       1);
    chk({tag, "_rgb"},    32'(rgb_out),     0);
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    c    = 0;
    m_pix = 0; m_line = 0; m_von = 0; m_fs = 0; m_hs = 0; m_vs = 0; m_rgb = 0;
    first_bad = -1;
    vis_cnt = 0; pix0_line0 = 0; hs_low0 = 0; hs_first = -1; vs_low = 0; vs_first = -1;
    fs_cnt = 0; fs_second = -1; rgb_ff_cnt = 0; rgb_nz_f1 = 0; rgb_in_hs = 0; line_nz = 0;

    // Reset held for 5 cycles
    repeat (5) @(negedge clk);
    chk_reset("reset");

    // Release; first sample after the first unreset edge is c=0
    rst = 1'b0;
    c   = -1;
    step();
    chk("first_pixel", 32'(pixel),       1);
    chk("first_line",  32'(line),        1);
    chk("first_von",   32'(video_on),    1);
    chk("first_fs",    32'(frame_start), 1);
    chk("first_hsync", 32'(hsync),       1);
    chk("first_vsync", 32'(vsync),       1);
    chk("first_rgb",   32'(rgb_out),     0);

    // Two full frames: frame 0 with constant white input, frame 1 with layer model
    while (c < 2 * FRAME) begin
      h   = c % LINE;
      v   = (c / LINE) % NLINE;
      vis = (h < 640) && (v < 4);
      if (c >= 2) begin
        hd   = (c - 2) % LINE;
        vd   = ((c - 2) / LINE) % NLINE;
        visd = (hd < 640) && (vd < 4);
        e_hs = !(hd >= 656 && hd <= 751);
        e_vs = !(vd >= 6 && vd <= 7);
      end else begin
        hd = 0; vd = 0; visd = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end
      e_pix  = vis ? h + 1 : 0;
      e_line = vis ? v + 1 : 0;
      if (!visd)          e_rgb = 0;
      else if (c < FRAME) e_rgb = 8'hFF;
      else                e_rgb = (hd < 15) ? 8'hA5 : 0;

      if (pixel !== 10'(e_pix))        m_pix++;
      if (line !== 9'(e_line))         m_line++;
      if (video_on !== vis)            m_von++;
      if (frame_start !== (h == 0 && v == 0)) m_fs++;
      if (hsync !== e_hs)              m_hs++;
      if (vsync !== e_vs)              m_vs++;
      if (rgb_out !== 8'(e_rgb))       m_rgb++;
      if (first_bad < 0 && (pixel !== 10'(e_pix) || line !== 9'(e_line) || hsync !== e_hs ||
                            vsync !== e_vs || rgb_out !== 8'(e_rgb)))
        first_bad = c;

      if (c < LINE) begin
        if (pixel == 10'd0) pix0_line0++;
        if (hsync == 1'b0) begin
          hs_low0++;
          if (hs_first < 0) hs_first = c;
        end
      end
      if (c < FRAME) begin
        if (video_on) vis_cnt++;
        if (line != 9'd0) line_nz++;
        if (rgb_out == 8'hFF) rgb_ff_cnt++;
        if (vsync == 1'b0) begin
          vs_low++;
          if (vs_first < 0) vs_first = c;
        end
      end else begin
        if (rgb_out != 8'h00) rgb_nz_f1++;
      end
      if (hsync == 1'b0 && rgb_out != 8'h00) rgb_in_hs++;
      if (frame_start) begin
        fs_cnt++;
        if (c > 0 && fs_second < 0) fs_second = c;
      end

      if (c == 639)            chk("pixel_640",      32'(pixel), 640);
      if (c == 640)            chk("pixel_after_640", 32'(pixel), 0);
      if (c == 2)              chk("rgb_first_vis",  32'(rgb_out), 8'hFF);
      if (c == 3 * LINE + 639) chk("line_last_vis",  32'(line), 4);
      if (c == 4 * LINE)       chk("line_first_blank", 32'(line), 0);
      if (c == 8000) mode = 1'b1;
      step();
    end

    chk("frame2_fs",    32'(frame_start), 1);
    chk("frame2_pixel", 32'(pixel),       1);

    if (first_bad >= 0) $display("first model deviation at cycle %0d", first_bad);
    chk("model_pixel", 32'(m_pix),  0);
    chk("model_line",  32'(m_line), 0);
    chk("model_von",   32'(m_von),  0);
    chk("model_fs",    32'(m_fs),   0);
    chk("model_hsync", 32'(m_hs),   0);
    chk("model_vsync", 32'(m_vs),   0);
    chk("model_rgb",   32'(m_rgb),  0);

    chk("vis_cycles_frame",   32'(vis_cnt),    2560);
    chk("blank_pixels_line",  32'(pix0_line0), 160);
    chk("hsync_low_len",      32'(hs_low0),    96);
    chk("hsync_first_low",    32'(hs_first),   658);
    chk("vsync_low_len",      32'(vs_low),     1600);
    chk("vsync_first_low",    32'(vs_first),   4802);
    chk("frame_start_count",  32'(fs_cnt),     2);
    chk("frame_start_period", 32'(fs_second),  FRAME);
    chk("line_nonzero",       32'(line_nz),    2560);
    chk("rgb_ff_cycles",      32'(rgb_ff_cnt), 2560);
    chk("rgb_layer_cycles",   32'(rgb_nz_f1),  60);
    chk("rgb_during_hsync",   32'(rgb_in_hs),  0);

    // Reset mid-frame at pixel=300, line=3
    found = 1'b0;
    n = 0;
    while (!found && n < 5000) begin
      if (pixel == 10'd300 && line == 9'd3) found = 1'b1;
      else begin step(); n++; end
    end
    chk("find_300_3", 32'(found), 1);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    step();
    chk("midrst_rel_pixel", 32'(pixel),       1);
    chk("midrst_rel_line",  32'(line),        1);
    chk("midrst_rel_fs",    32'(frame_start), 1);
    chk("midrst_rel_von",   32'(video_on),    1);

    // Reset while hsync is low: no partial pulse may survive
    found = 1'b0;
    n = 0;
    while (!found && n < 1000) begin
      if (hsync == 1'b0) found = 1'b1;
      else begin step(); n++; end
    end
    chk("find_hsync_low", 32'(found), 1);
    rst = 1'b1;
    step();
    chk_reset("hsrst");
    rst = 1'b0;
    step();
    chk("hsrst_rel_pixel", 32'(pixel), 1);
    early_low = 1'b0;
    hs_at_658 = 1'b1;
    for (k = 0; k < 700; k++) begin
      if (k < 658 && hsync !== 1'b1) early_low = 1'b1;
      if (k == 658) hs_at_658 = hsync;
      step();
    end
    chk("hsrst_no_partial", 32'(early_low), 0);
    chk("hsrst_hsync_658",  32'(hs_at_658), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
